// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_SUM,
        ST_DONE
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Largest word count that fits in a RAM of 2**addr_w words.
    function automatic logic [16:0] max_len_words(input int addr_w);
        logic [16:0] one;
        one = 17'd1;
        return one << addr_w;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: synchroniser, mid-bit sampling down-counter, shift register.
// byte_valid / frame_err pulse in the cycle the stop bit is sampled.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLK_DIV = 139
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ser_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLK_DIV / 2 - 1);

    rx_state_e        rx_state_q, rx_state_d;
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    logic rx_s;
    logic fall;
    logic tc;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detect
    assign rx_s      = sync_q[1];
    assign fall      = sync_q[2] & ~sync_q[1];
    assign tc        = (cnt_q == '0);
    assign byte_data = shift_q;

    always_comb begin
        sync_d     = {sync_q[1:0], ser_rx};
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (fall) begin
                    rx_state_d = RX_START;
                    cnt_d      = HALF_LD;
                end
            end
            RX_START: begin
                if (!tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    cnt_d      = FULL_LD;
                    bit_d      = 3'd0;
                end
            end
            RX_DATA: begin
                if (!tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (!tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rx_state_d = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = ~rx_s;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_q <= RX_IDLE;
            sync_q     <= 3'b111;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/serial_program_loader.sv
// Boot loader: receives a framed image over serial and writes 32-bit LE words to instruction RAM.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte before releasing the CPU.
//
// state | meaning
// SYNC  | hunting for the 0xA5 sync byte
// LEN0  | expecting word count low byte
// LEN1  | expecting word count high byte, range check
// DATA  | assembling and writing image words
// SUM   | expecting checksum byte (checksum builds only)
// DONE  | image loaded, cpu_run held, input ignored until reset
module serial_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_DIV = 139,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ser_rx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              cpu_run,
    output logic              load_err,
    output logic              busy
);

    logic       rx_valid;
    logic       rx_err;
    logic [7:0] rx_data;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .ser_rx    (ser_rx),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_err)
    );

    ld_state_e         state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              cpu_run_q, cpu_run_d;
    logic              load_err_q, load_err_d;
    logic              busy_q, busy_d;

    logic [15:0] len_rx;
    logic [16:0] idx_inc;
    logic        image_end;

    assign len_rx  = {rx_data, len_lo_q};
    assign idx_inc = 17'(idx_q) + 17'd1;

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        sum_d       = sum_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        cpu_run_d   = cpu_run_q;
        load_err_d  = load_err_q;
        busy_d      = busy_q;
        image_end   = 1'b0;

        if (rx_err) begin
            if (state_q != ST_DONE) begin
                load_err_d = 1'b1;
            end
            if (state_q != ST_SYNC && state_q != ST_DONE) begin
                state_d = ST_SYNC;
                busy_d  = 1'b0;
            end
        end else if (rx_valid) begin
            case (state_q)
                ST_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        load_err_d = 1'b0;
                        idx_d      = '0;
                        sum_d      = 8'd0;
                        bcnt_d     = 2'd0;
                        busy_d     = 1'b1;
                        state_d    = ST_LEN0;
                    end
                end
                ST_LEN0: begin
                    len_lo_d = rx_data;
                    sum_d    = sum_q + rx_data;
                    state_d  = ST_LEN1;
                end
                ST_LEN1: begin
                    sum_d = sum_q + rx_data;
                    len_d = len_rx;
                    if ({1'b0, len_rx} > max_len_words(ADDR_W)) begin
                        load_err_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_SYNC;
                    end else if (len_rx == 16'd0) begin
                        image_end = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    sum_d  = sum_q + rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            ram_we_d    = 1'b1;
                            ram_addr_d  = idx_q[ADDR_W-1:0];
                            ram_wdata_d = {rx_data, word_q};
                            idx_d       = idx_inc[ADDR_W:0];
                            image_end   = (idx_inc == {1'b0, len_q});
                        end
                    endcase
                end
`ifdef LOADER_CHECKSUM_EN
                ST_SUM: begin
                    busy_d = 1'b0;
                    if (rx_data == sum_q) begin
                        cpu_run_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ST_SYNC;
                    end
                end
`endif
                default: ;
            endcase
        end

        if (image_end) begin
`ifdef LOADER_CHECKSUM_EN
            state_d   = ST_SUM;
`else
            state_d   = ST_DONE;
            cpu_run_d = 1'b1;
            busy_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_SYNC;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            idx_q       <= '0;
            bcnt_q      <= 2'd0;
            word_q      <= 24'd0;
            sum_q       <= 8'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            ram_we_q    <= 1'b0;
            cpu_run_q   <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            cpu_run_q   <= cpu_run_d;
            load_err_q  <= load_err_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign cpu_run   = cpu_run_q;
    assign load_err  = load_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_program_loader.sv
// Scoreboard bench for serial_program_loader: expected RAM writes queued as bytes are sent.
// Honours LOADER_CHECKSUM_EN to match the DUT build.
module tb_serial_program_loader;

    localparam int CLK_DIV = 8;
    localparam int ADDR_W  = 11;
`ifdef LOADER_CHECKSUM_EN
    localparam bit HAS_SUM = 1'b1;
`else
    localparam bit HAS_SUM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              ser_rx = 1'b1;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              cpu_run;
    logic              load_err;
    logic              busy;

    serial_program_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ser_rx   (ser_rx),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .cpu_run  (cpu_run),
        .load_err (load_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [31:0]       tx_words[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && ram_we) begin
            if (exp_addr_q.size() == 0) begin
                chk("we_without_expect", 32'(ram_we), 32'd0);
            end else begin
                chk("we_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
                chk("we_data", ram_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        chk("sb_empty_before_reset", 32'(exp_addr_q.size()), 32'd0);
        ser_rx = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] n, input bit bad_sum);
        logic [7:0] sum;
        logic [7:0] b;
        sum = n[7:0] + n[15:8];
        send_byte(8'hA5, 1'b1);
        chk("busy_after_sync", 32'(busy), 32'd1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
        for (int i = 0; i < tx_words.size(); i++) begin
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(tx_words[i]);
            for (int k = 0; k < 4; k++) begin
                b   = tx_words[i][8*k +: 8];
                sum = sum + b;
                send_byte(b, 1'b1);
            end
        end
        if (HAS_SUM) send_byte(bad_sum ? sum + 8'd1 : sum, 1'b1);
    endtask

    task automatic chk_status(input string tag, input logic exp_run, input logic exp_err, input logic exp_busy);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_run));
        chk({tag, "_load_err"}, 32'(load_err), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // basic two-word image
        tx_words = '{32'h12345678, 32'hDEADBEEF};
        send_frame(16'd2, 1'b0);
        settle();
        chk_status("basic", 1'b1, 1'b0, 1'b0);
        // DONE ignores a new sync byte
        send_byte(8'hA5, 1'b1);
        settle();
        chk_status("done_ignore", 1'b1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send_frame(16'd2, 1'b1);
        settle();
        chk_status("bad_sum", 1'b0, 1'b1, 1'b0);
        send_frame(16'd2, 1'b0);
        settle();
        chk_status("after_bad_sum", 1'b1, 1'b0, 1'b0);
`endif

        // glitch and garbage ahead of the frame
        do_reset();
        ser_rx = 1'b0;
        repeat (2) @(negedge clk);
        ser_rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        chk_status("glitch", 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h13, 1'b1);
        tx_words = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h01020304};
        send_frame(16'd3, 1'b0);
        settle();
        chk_status("garbage", 1'b1, 1'b0, 1'b0);

        // framing error on second data byte
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b0);
        settle();
        chk_status("frame_err", 1'b0, 1'b1, 1'b0);

        // length one past RAM size, then exactly RAM size accepted
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h08, 1'b1);
        settle();
        chk_status("len_over", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        settle();
        chk_status("len_max", 1'b0, 1'b0, 1'b1);

        // zero-length image
        do_reset();
        tx_words = {};
        send_frame(16'd0, 1'b0);
        settle();
        chk_status("len_zero", 1'b1, 1'b0, 1'b0);

        // reset in the middle of DATA
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_addr_q.push_back(ADDR_W'(0));
        exp_data_q.push_back(32'h11223344);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h99, 1'b1);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        tx_words = '{32'hAAAA5555, 32'h0F0F0F0F};
        send_frame(16'd2, 1'b0);
        settle();
        chk_status("after_reset", 1'b1, 1'b0, 1'b0);

        chk("sb_empty_end", 32'(exp_addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
